// File: rtl/alu_seq_unit.sv
// alu_seq_unit: registered single-cycle ALU with built-in funct decode,
// plus an iterative unsigned multiply/divide engine writing HI/LO.
// Single-cycle ops complete one cycle after acceptance; multu/divu take
// WIDTH iteration cycles and then pulse done.
module alu_seq_unit #(
  parameter int WIDTH = 32,
  parameter int SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SW-1:0]    shamt,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             dbz,
  output logic             illegal,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // Iteration counter holds WIDTH itself, so it needs one bit more than SW.
  localparam int CW = $clog2(WIDTH) + 1;

  // Op classes supplied by the main control unit.
  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_FUNCT = 2'b10;
  localparam logic [1:0] OP_OR    = 2'b11;

  // MIPS funct encodings handled by the decoder.
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]      cnt;
  // acc: MUL = {partial product, remaining multiplier bits};
  //      DIV = {partial remainder, dividend shifting into quotient}.
  logic [2*WIDTH-1:0] acc;
  // opnd: multiplicand for MUL, divisor for DIV.
  logic [WIDTH-1:0]   opnd;

  logic               accept;
  logic               last_step;

  // Single-cycle datapath signals.
  logic [WIDTH-1:0]   sum, diff;
  logic               add_ovf, sub_ovf;
  logic               slt_flag, sltu_flag;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_ovf;
  logic               alu_ill;
  logic               start_mul;
  logic               start_div;

  // Iteration datapath signals.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] step_next;

  assign busy      = (state != S_IDLE);
  assign in_ready  = !busy;
  assign accept    = valid_in && in_ready;
  assign last_step = busy && (cnt == CW'(1));

  assign sum       = a + b;
  assign diff      = a - b;
  // Signed overflow: operands agree in sign (add) or differ (sub) and
  // the wrapped result's sign differs from a.
  assign add_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1]  != a[WIDTH-1]);
  assign sub_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
  assign slt_flag  = ($signed(a) < $signed(b));
  assign sltu_flag = (a < b);

  // Decode op class / funct into a single-cycle result or a multi-cycle start.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // that no path through the case statements leaves it unassigned (latch).
    alu_res   = '0;
    alu_ovf   = 1'b0;
    alu_ill   = 1'b0;
    start_mul = 1'b0;
    start_div = 1'b0;
    case (alu_op)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = add_ovf;
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = sub_ovf;
      end
      OP_OR: alu_res = a | b;
      OP_FUNCT: begin
        case (funct)
          F_ADD: begin
            alu_res = sum;
            alu_ovf = add_ovf;
          end
          F_ADDU: alu_res = sum;
          F_SUB: begin
            alu_res = diff;
            alu_ovf = sub_ovf;
          end
          F_SUBU:  alu_res = diff;
          F_AND:   alu_res = a & b;
          F_OR:    alu_res = a | b;
          F_XOR:   alu_res = a ^ b;
          F_NOR:   alu_res = ~(a | b);
          F_SLT:   alu_res = {{(WIDTH-1){1'b0}}, slt_flag};
          F_SLTU:  alu_res = {{(WIDTH-1){1'b0}}, sltu_flag};
          F_SLL:   alu_res = b << shamt;
          F_SRL:   alu_res = b >> shamt;
          F_SRA:   alu_res = $unsigned($signed(b) >>> shamt);
          F_MFHI:  alu_res = hi;
          F_MFLO:  alu_res = lo;
          F_MULTU: start_mul = 1'b1;
          F_DIVU:  start_div = 1'b1;
          default: alu_ill = 1'b1;
        endcase
      end
      default: alu_res = '0;
    endcase
  end

  // One shift-add or restoring-divide iteration on the working register.
  always_comb begin
    // Shift-add: add multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole product right by one.
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next  = {mul_sum, acc[WIDTH-1:1]};
    // Restoring divide: bring the next dividend bit into the remainder and
    // keep the subtraction only when it does not go negative. A zero divisor
    // always "succeeds", giving an all-ones quotient and remainder = a.
    rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = {1'b0, rem_shift} - {2'b00, opnd};
    if (div_diff[WIDTH+1])
      div_next = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    else
      div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    step_next = (state == S_MUL) ? mul_next : div_next;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // FSM next state: start a multi-cycle op from IDLE, return after WIDTH steps.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (accept && start_mul)      state_nx = S_MUL;
        else if (accept && start_div) state_nx = S_DIV;
      end
      S_MUL, S_DIV: begin
        if (last_step) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath registers: result/flags, HI/LO and the iteration engine.
  always_ff @(posedge clk) begin
    if (rst) begin
      result  <= '0;
      zero    <= 1'b1;
      done    <= 1'b0;
      ovf     <= 1'b0;
      dbz     <= 1'b0;
      illegal <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      acc     <= '0;
      opnd    <= '0;
      cnt     <= '0;
    end else begin
      // done and the flags are single-cycle pulses unless set below.
      done    <= 1'b0;
      ovf     <= 1'b0;
      dbz     <= 1'b0;
      illegal <= 1'b0;
      if (!busy) begin
        if (accept) begin
          if (start_mul) begin
            acc  <= {{WIDTH{1'b0}}, b};
            opnd <= a;
            cnt  <= CW'(WIDTH);
          end else if (start_div) begin
            acc  <= {{WIDTH{1'b0}}, a};
            opnd <= b;
            cnt  <= CW'(WIDTH);
          end else begin
            result  <= alu_res;
            zero    <= (alu_res == '0);
            done    <= 1'b1;
            ovf     <= alu_ovf;
            illegal <= alu_ill;
          end
        end
      end else begin
        acc <= step_next;
        cnt <= cnt - CW'(1);
        if (last_step) begin
          hi     <= step_next[2*WIDTH-1:WIDTH];
          lo     <= step_next[WIDTH-1:0];
          result <= step_next[WIDTH-1:0];
          zero   <= (step_next[WIDTH-1:0] == '0);
          done   <= 1'b1;
          dbz    <= (state == S_DIV) && (opnd == '0);
        end
      end
    end
  end

endmodule

// File: doc/alu_seq_unit.md
# alu_seq_unit

Parametrised, registered ALU with integrated function decode and a multi-cycle multiply/divide engine for the multi-cycle CPU datapath. It sits between the main control unit, which supplies the 2-bit ALU op class, and the register file, which supplies the operands. It decodes the instruction funct field itself and writes results through one output register. Unsigned multiply and divide run iteratively into internal HI/LO registers under a ready/busy/done handshake.

## Interface
- WIDTH, 32, operand/result width; legal values are powers of two, 8 to 64.
- SW, $clog2(WIDTH), shift-amount width; derived, do not override.

- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_in  in  1  operation request; accepted on a rising edge when valid_in && in_ready.
- alu_op  in  2  op class: 00 add (lw/sw), 01 sub (beq), 10 decode funct, 11 or (ori).
- funct  in  6  MIPS funct field; used only when alu_op=10.
- a  in  WIDTH  operand A (rs).
- b  in  WIDTH  operand B (rt or extended immediate).
- shamt  in  SW  shift amount for sll/srl/sra.
- in_ready  out  1  combinational: !busy.
- busy  out  1  multiply/divide in progress.
- done  out  1  one-cycle pulse; result and flags are valid this cycle.
- result  out  WIDTH  registered result.
- zero  out  1  registered (result == 0).
- ovf  out  1  signed overflow, add/sub only.
- dbz  out  1  divide by zero, divu only.
- illegal  out  1  unsupported funct.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- Supported funct codes (binary):
  - Arithmetic: add 100000, addu 100001, sub 100010, subu 100011.
  - Logic: and 100100, or 100101, xor 100110, nor 100111.
  - Compare: slt 101010 (signed), sltu 101011.
  - Shifts: sll 000000, srl 000010, sra 000011; all shift b by shamt.
  - HI/LO moves: mfhi 010000, mflo 010010.
  - Multi-cycle: multu 011001, divu 011011.
- Arithmetic is modulo 2^WIDTH.
- ovf is set for add/sub (alu_op 00/01 and funct add/sub) when signed overflow occurs. The wrapped result is still written; there is no trap. addu/subu never set ovf.
- slt/sltu: result = {WIDTH-1 zeros, flag}.
- Any other funct under alu_op=10: result=0, zero=1, illegal=1. hi/lo are unchanged.
- States are IDLE, MUL and DIV. A 6-bit iteration counter runs WIDTH down to 0.
  - IDLE: a single-cycle op is accepted and registered; done=1 next cycle; stay in IDLE.
  - IDLE to MUL on an accepted multu. Shift-add runs one bit per cycle for WIDTH cycles. Then {hi,lo} = a*b (full 2*WIDTH product) and the state returns to IDLE.
  - IDLE to DIV on an accepted divu. Restoring division runs one quotient bit per cycle for WIDTH cycles. Then lo = a/b, hi = a%b, and the state returns to IDLE.
- Divide by zero: the algorithm runs its normal WIDTH cycles and yields lo = all ones, hi = a, with dbz=1 on done.
- On done for multu/divu, result = lo and zero reflects lo.
- Flags ovf, dbz and illegal are valid only while done=1 and are 0 otherwise.
- Operands are latched at acceptance, so a, b, funct and alu_op may change freely while busy.
- valid_in while busy is ignored and not queued. Upstream must hold the request until in_ready=1.
- mfhi/mflo read hi/lo as they are at acceptance.

## Timing
- Reset state: IDLE, counter 0. Outputs after reset:
  - result=0, hi=0, lo=0.
  - done=0, busy=0, ovf=0, dbz=0, illegal=0.
  - zero=1.
- Single-cycle op accepted at edge k: result/zero/flags update at edge k; done=1 during cycle k+1. Latency is 1, throughput one op per cycle.
- multu/divu accepted at edge k:
  - busy=1 and in_ready=0 during cycles k+1 .. k+WIDTH.
  - hi, lo and result update at edge k+WIDTH.
  - done=1 and busy=0 during cycle k+WIDTH+1.
  - A new op may be accepted at the end of the done cycle. Back-to-back multi-cycle ops therefore issue every WIDTH+1 cycles.
- result holds its value until the next completed op. hi/lo change only on multu/divu completion or on rst.
- rst mid-operation aborts the op with no done pulse and returns all outputs to their reset values at that edge.
- rst together with valid_in: rst wins and the request is dropped.

## Test plan
- WIDTH=32. add a=0x7FFFFFFF, b=1 (alu_op=10, funct 100000) -> next cycle done=1, result=0x80000000, ovf=1, zero=0. The same operands with addu -> ovf=0.
- Back-to-back: sub 5-5, then slt a=0xFFFFFFFF b=1, then sltu with the same operands, on consecutive cycles -> three consecutive done pulses: result 0 with zero=1, result 1, result 0.
- multu a=0xFFFFFFFF, b=0xFFFFFFFF -> busy high exactly 32 cycles, then done with hi=0xFFFFFFFE, lo=0x00000001. valid_in pulsed while busy is ignored. A following mfhi returns 0xFFFFFFFE.
- divu a=100, b=7 -> done after 33 cycles with lo=14, hi=2, dbz=0. divu a=100, b=0 -> lo=0xFFFFFFFF, hi=100, dbz=1.
- funct 111111 under alu_op=10 -> done with illegal=1, result=0, hi/lo unchanged. sra b=0x80000000, shamt=4 -> 0xF8000000.
- rst asserted in the 10th busy cycle of a multu -> no done pulse, hi=lo=0, busy=0 the next cycle. A fresh add is accepted on the following edge.
